f2c_burst_fifo: RTL and testbench
=================================

// Module: f2c_burst_fifo
// PURPOSE
//   Upstream feeder for the FPGA->CPU DMA pipe of tlp_send. Buffers the application's 64-bit
//   stream and presents it only in complete 16-QW bursts (one DmaWrite TLP payload). The consumer
//   checks f2cValid once, then pulls 16 QWs back-to-back, so a started burst never stalls.
//   Partial bursts are padded out after an idle timeout so tail data still reaches the CPU.
// PARAMETERS
//   DEPTH_BURSTS  4                  storage capacity in 16-QW bursts (power of two, >=2)
//   TIMEOUT       1024               idle cycles before padding a partial burst; 0 = never pad
//   PAD_WORD      64'hFFFFFFFFFFFFFFFF  value written into padded slots
// PORTS
//   pcieClk_in     in   1   125MHz PCIe core clock; all logic on its rising edge
//   pcieReset_in   in   1   synchronous, active-high reset
//   appData_in     in   64  application data word
//   appValid_in    in   1   appData_in valid
//   appReady_out   out  1   word accepted when appValid_in && appReady_out
//   f2cData_out    out  64  head word, first-word-fall-through
//   f2cValid_out   out  1   >=1 complete burst stored
//   f2cReady_in    in   1   consumer takes f2cData_out this cycle
//   f2cReset_in    in   1   flush request from tlp_send (DMA disable)
//   level_out      out  $clog2(DEPTH_BURSTS*16)+1  QWs stored (committed + partial)
//   padCount_out   out  32  number of bursts completed by padding
// BEHAVIOUR
//   Reset (pcieReset_in=1 at edge): pointers, level, burst count, timeout counter, padCount = 0;
//     FSM -> S_FILL. While pcieReset_in is high: appReady_out=0, f2cValid_out=0.
//   Storage: DEPTH_BURSTS*16 x 64 circular RAM; wrPtr/rdPtr wrap modulo capacity.
//   Write: appReady_out = !pcieReset_in && !f2cReset_in && state==S_FILL && level<capacity.
//     Accepted word stored at wrPtr; wrPtr++, fill index (wrPtr[3:0]) advances.
//   Commit: when the 16th word of a burst is written (fill index 15), readyBursts++ at that edge.
//     f2cValid_out = (readyBursts != 0), registered: rises the cycle after the 16th write.
//   Read: f2cData_out = mem[rdPtr] combinationally valid whenever f2cValid_out. On f2cReady_in &&
//     f2cValid_out: rdPtr++; when rdPtr[3:0] wraps 15->0, readyBursts-- at that edge.
//     f2cValid_out must remain high throughout an in-progress burst (guaranteed: burst is whole).
//     f2cReady_in while f2cValid_out=0 is ignored (no pointer change).
//   Simultaneous commit and burst-end read: readyBursts net unchanged. level_out += writes - reads.
//   FSM:
//     S_FILL: idle counter increments each cycle with fill index in 1..15 and no accepted write;
//       cleared on any accepted write or fill index 0. TIMEOUT!=0 && counter==TIMEOUT-1 -> S_PAD.
//     S_PAD: appReady_out=0; writes PAD_WORD at wrPtr one per cycle (not gated by level, space is
//       guaranteed by the reserved partial burst). Write at fill index 15 commits the burst,
//       padCount_out++, -> S_FILL.
//   Full: level_out == capacity -> appReady_out=0; freed the cycle after a read reduces level.
//   Empty partial burst never pads (fill index 0 keeps counter at 0).
//   Flush: f2cReset_in=1 at an edge clears pointers, level, readyBursts, counter, padCount;
//     FSM -> S_FILL; any read or write that cycle is discarded; f2cValid_out=0 next cycle.
//   pcieReset_in overrides f2cReset_in; both override all other activity incl. S_PAD.
//   padCount_out saturates at 32'hFFFFFFFF.
// TESTING
//   1 Write 0..15 continuously -> f2cValid_out=1 one cycle after 16th accept; ready held high
//     -> f2cData_out 0..15 in order, valid high all 16 cycles, then 0; level_out 16->0.
//   2 TIMEOUT=8: write 0..14, idle -> S_PAD after 8 idle cycles, slot 15 = PAD_WORD,
//     f2cValid_out rises, padCount_out=1, drained burst = 0..14,PAD_WORD.
//   3 Write 64 words, ready low -> appReady_out=0 after 64th, level_out=64; drain 16
//     -> appReady_out=1 next cycle, readyBursts 3.
//   4 Two bursts stored, drain 5 words, pulse f2cReset_in -> next cycle f2cValid_out=0,
//     level_out=0, padCount_out=0; new 16-word burst then delivered from its first word.
//   5 Stream 400 incrementing words, random appValid_in/f2cReady_in (ready only while valid)
//     -> output sequence matches input exactly across pointer wrap, no loss/duplication.
//   6 pcieReset_in asserted mid-S_PAD -> next cycle all outputs at reset values, FSM S_FILL,
//     no padded burst committed.

Source files
------------

// File: rtl/f2c_burst_fifo_if.sv
// Handshake bundle between the application stream, the burst FIFO and the tlp_send consumer.
interface f2c_burst_fifo_if;
  logic [63:0] appData_in;
  logic        appValid_in;
  logic        appReady_out;
  logic [63:0] f2cData_out;
  logic        f2cValid_out;
  logic        f2cReady_in;

  modport slave (
    input  appData_in, appValid_in, f2cReady_in,
    output appReady_out, f2cData_out, f2cValid_out
  );

  modport master (
    output appData_in, appValid_in, f2cReady_in,
    input  appReady_out, f2cData_out, f2cValid_out
  );
endinterface

// File: rtl/f2c_burst_fifo.sv
// FPGA->CPU DMA feeder: buffers the 64-bit app stream and releases it only in whole 16-QW bursts,
// padding a stalled partial burst after an idle timeout.
module f2c_burst_fifo #(
  parameter int unsigned DEPTH_BURSTS = 4,
  parameter int unsigned TIMEOUT      = 1024,
  parameter logic [63:0] PAD_WORD     = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                                pcieClk_in,
  input  logic                                pcieReset_in,
  input  logic                                f2cReset_in,
  f2c_burst_fifo_if.slave                     dmaBus,
  output logic [$clog2(DEPTH_BURSTS*16):0]    level_out,
  output logic [31:0]                         padCount_out
);
  localparam int unsigned CAP = DEPTH_BURSTS * 16;
  localparam int unsigned AW  = $clog2(CAP);
  localparam int unsigned LW  = AW + 1;
  localparam int unsigned BW  = $clog2(DEPTH_BURSTS) + 1;

  typedef enum logic {S_FILL, S_PAD} state_t;

  state_t          state;
  logic [63:0]     mem [CAP];
  logic [AW-1:0]   wrPtr, rdPtr;
  logic [BW-1:0]   readyBursts;
  logic [31:0]     idleCnt;
  logic            clear, fillWr, padWr, wr, rd, commit, burstEnd;
  logic [63:0]     wrData;

  assign clear  = pcieReset_in || f2cReset_in;
  assign dmaBus.appReady_out = !clear && (state == S_FILL) && (level_out < LW'(CAP));
  assign fillWr = dmaBus.appValid_in && dmaBus.appReady_out;
  // Padding needs no level check: the partial burst being padded already owns its slots.
  assign padWr  = !clear && (state == S_PAD);
  assign wr     = fillWr || padWr;
  assign wrData = padWr ? PAD_WORD : dmaBus.appData_in;

  assign dmaBus.f2cValid_out = !pcieReset_in && (readyBursts != '0);
  assign dmaBus.f2cData_out  = mem[rdPtr];
  assign rd       = !clear && dmaBus.f2cReady_in && dmaBus.f2cValid_out;
  assign commit   = wr && (wrPtr[3:0] == 4'hF);
  assign burstEnd = rd && (rdPtr[3:0] == 4'hF);

  always_ff @(posedge pcieClk_in) begin
    if (wr) mem[wrPtr] <= wrData;
  end

  always_ff @(posedge pcieClk_in) begin
    if (clear) begin
      state        <= S_FILL;
      wrPtr        <= '0;
      rdPtr        <= '0;
      level_out    <= '0;
      readyBursts  <= '0;
      idleCnt      <= '0;
      padCount_out <= '0;
    end else begin
      if (wr) wrPtr <= wrPtr + AW'(1);
      if (rd) rdPtr <= rdPtr + AW'(1);
      level_out   <= level_out + LW'(wr) - LW'(rd);
      readyBursts <= readyBursts + BW'(commit) - BW'(burstEnd);

      unique case (state)
        S_FILL: begin
          // An empty fill index never ages, so an idle FIFO never pads.
          if (fillWr || wrPtr[3:0] == 4'h0) begin
            idleCnt <= '0;
          end else if (TIMEOUT != 0 && idleCnt == TIMEOUT - 1) begin
            idleCnt <= '0;
            state   <= S_PAD;
          end else begin
            idleCnt <= idleCnt + 32'd1;
          end
        end
        S_PAD: begin
          if (wrPtr[3:0] == 4'hF) begin
            state <= S_FILL;
            if (padCount_out != '1) padCount_out <= padCount_out + 32'd1;
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_f2c_burst_fifo.sv
// Directed bench for f2c_burst_fifo with a queue-level reference model checked every cycle.
module tb_f2c_burst_fifo;
  localparam int unsigned TO  = 8;
  localparam int unsigned CAP = 64;
  localparam logic [63:0] PAD = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        pcieReset, f2cReset;
  logic [6:0]  level;
  logic [31:0] padCount;

  f2c_burst_fifo_if bus ();

  f2c_burst_fifo #(.DEPTH_BURSTS(4), .TIMEOUT(TO), .PAD_WORD(PAD)) dut (
    .pcieClk_in   (clk),
    .pcieReset_in (pcieReset),
    .f2cReset_in  (f2cReset),
    .dmaBus       (bus),
    .level_out    (level),
    .padCount_out (padCount)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    else passed++;
  endtask

  // Reference model: stored words in order, words in the not-yet-complete burst, idle age, pad mode.
  logic [63:0] q[$];
  int          partial = 0;
  int          idle    = 0;
  bit          padding = 0;
  logic [31:0] mPad    = '0;
  bit          checkEn = 0;

  always begin
    bit expReady, expValid, acc, rd, r, f;
    logic [63:0] d;
    @(negedge clk);
    expReady = !pcieReset && !f2cReset && !padding && (q.size() < CAP);
    expValid = !pcieReset && ((q.size() - partial) > 0);
    if (checkEn) begin
      chk("appReady", bus.appReady_out, expReady);
      chk("f2cValid", bus.f2cValid_out, expValid);
      chk("level", level, q.size());
      chk("padCount", padCount, mPad);
      if (expValid) chk("f2cData", bus.f2cData_out, q[0]);
    end
    acc = bus.appValid_in && expReady;
    rd  = bus.f2cReady_in && expValid;
    d   = bus.appData_in;
    r   = pcieReset;
    f   = f2cReset;
    @(posedge clk);
    if (r || f) begin
      q.delete();
      partial = 0; idle = 0; padding = 0; mPad = '0;
    end else begin
      if (rd) void'(q.pop_front());
      if (padding) begin
        q.push_back(PAD);
        partial++;
        if (partial == 16) begin
          partial = 0; padding = 0;
          if (mPad != 32'hFFFF_FFFF) mPad++;
        end
      end else if (acc) begin
        q.push_back(d);
        partial = (partial + 1) % 16;
        idle = 0;
      end else if (partial != 0) begin
        idle++;
        if (idle == TO) begin padding = 1; idle = 0; end
      end else begin
        idle = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Holds appValid with the given word until accepted; leaves appValid high.
  task automatic pushWord(input logic [63:0] dv);
    bit got = 0;
    bus.appValid_in = 1'b1;
    bus.appData_in  = dv;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = bus.appReady_out;
      @(posedge clk); #1;
    end
    if (!got) begin
      total++;
      $display("FAIL push_timeout actual=not_accepted required=accepted data=%h", dv);
    end
  endtask

  task automatic drain(input int n);
    bus.f2cReady_in = 1'b1;
    repeat (n) cyc();
    bus.f2cReady_in = 1'b0;
  endtask

  initial begin
    int n, sent, recv, idleRun;
    pcieReset = 1'b1; f2cReset = 1'b0;
    bus.appValid_in = 1'b0; bus.appData_in = '0; bus.f2cReady_in = 1'b0;
    cyc();
    checkEn = 1;
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_appReady", bus.appReady_out, 1'b0);
    chk("rst_f2cValid", bus.f2cValid_out, 1'b0);
    @(posedge clk); #1;
    pcieReset = 1'b0;
    @(negedge clk);
    chk("rst_level", level, 7'd0);
    chk("rst_padCount", padCount, 32'd0);
    @(posedge clk); #1;

    // 1: one full burst straight through
    for (int i = 0; i < 16; i++) pushWord(64'(i));
    bus.appValid_in = 1'b0;
    @(negedge clk);
    chk("t1_valid", bus.f2cValid_out, 1'b1);
    chk("t1_level", level, 7'd16);
    chk("t1_first", bus.f2cData_out, 64'd0);
    @(posedge clk); #1;
    drain(16);
    @(negedge clk);
    chk("t1_validAfter", bus.f2cValid_out, 1'b0);
    chk("t1_levelAfter", level, 7'd0);
    @(posedge clk); #1;

    // 2: partial burst padded after TO idle cycles
    for (int i = 0; i < 15; i++) pushWord(64'(100 + i));
    bus.appValid_in = 1'b0;
    n = 0;
    while (!bus.f2cValid_out && n < 40) begin cyc(); n++; end
    chk("t2_padLatency", 64'(n), 64'd9);
    chk("t2_padCount", padCount, 32'd1);
    chk("t2_level", level, 7'd16);
    bus.f2cReady_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0)  chk("t2_first", bus.f2cData_out, 64'd100);
      if (i == 15) chk("t2_padSlot", bus.f2cData_out, PAD);
      @(posedge clk); #1;
    end
    bus.f2cReady_in = 1'b0;

    // 3: fill to capacity, then free one burst
    for (int i = 0; i < 64; i++) pushWord(64'(200 + i));
    bus.appData_in = 64'd264;
    @(negedge clk);
    chk("t3_fullReady", bus.appReady_out, 1'b0);
    chk("t3_fullLevel", level, 7'd64);
    @(posedge clk); #1;
    bus.appValid_in = 1'b0;
    drain(16);
    @(negedge clk);
    chk("t3_freedReady", bus.appReady_out, 1'b1);
    chk("t3_level48", level, 7'd48);
    chk("t3_head", bus.f2cData_out, 64'd216);
    @(posedge clk); #1;
    drain(48);

    // 4: flush mid-burst, then a fresh burst starts from its first word
    for (int i = 0; i < 32; i++) pushWord(64'(300 + i));
    bus.appValid_in = 1'b0;
    drain(5);
    f2cReset = 1'b1; bus.appValid_in = 1'b1; bus.appData_in = 64'hDEAD; bus.f2cReady_in = 1'b1;
    cyc();
    f2cReset = 1'b0; bus.appValid_in = 1'b0; bus.f2cReady_in = 1'b0;
    @(negedge clk);
    chk("t4_valid", bus.f2cValid_out, 1'b0);
    chk("t4_level", level, 7'd0);
    chk("t4_padCount", padCount, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) pushWord(64'(400 + i));
    bus.appValid_in = 1'b0;
    @(negedge clk);
    chk("t4_newFirst", bus.f2cData_out, 64'd400);
    @(posedge clk); #1;
    drain(16);

    // 5: random stream across pointer wrap
    sent = 0; recv = 0; idleRun = 0;
    for (int c = 0; c < 6000 && recv < 400; c++) begin
      bus.appValid_in = (sent < 400) && (idleRun >= 2 || $urandom_range(0, 3) != 0);
      bus.appData_in  = 64'(1000 + sent);
      bus.f2cReady_in = bus.f2cValid_out && ($urandom_range(0, 1) != 0);
      @(negedge clk);
      if (bus.appValid_in && bus.appReady_out) sent++;
      if (bus.f2cReady_in && bus.f2cValid_out) begin
        chk("t5_stream", bus.f2cData_out, 64'(1000 + recv));
        recv++;
      end
      idleRun = bus.appValid_in ? 0 : idleRun + 1;
      @(posedge clk); #1;
    end
    bus.appValid_in = 1'b0; bus.f2cReady_in = 1'b0;
    chk("t5_count", 64'(recv), 64'd400);

    // 6: reset in the middle of padding
    for (int i = 0; i < 5; i++) pushWord(64'(500 + i));
    bus.appValid_in = 1'b0;
    repeat (8) cyc();
    @(negedge clk);
    chk("t6_padReady", bus.appReady_out, 1'b0);
    @(posedge clk); #1;
    pcieReset = 1'b1;
    cyc();
    pcieReset = 1'b0;
    @(negedge clk);
    chk("t6_level", level, 7'd0);
    chk("t6_valid", bus.f2cValid_out, 1'b0);
    chk("t6_ready", bus.appReady_out, 1'b1);
    chk("t6_padCount", padCount, 32'd0);
    @(posedge clk); #1;
    repeat (30) cyc();
    @(negedge clk);
    chk("t6_noCommit", bus.f2cValid_out, 1'b0);
    chk("t6_levelLate", level, 7'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
